kamus_wb_unit: RTL
==================

// Module: kamus_wb_unit
// PURPOSE
//  Parametrised write-back stage: registers the MEM/WB boundary and drives the register-file write port.
//  Waits for a multi-cycle L1D load response, then aligns and sign/zero-extends the load data.
//  Selects ALU / MEM / NEXT_PC / CSR data as the write-back value.
//  Back-pressures MEM through a valid/ready handshake; sits between the MEM stage and the regfile.
// PARAMETERS
//  XLEN          32  datapath width; legal values 32 or 64
//  RF_AW         5   regfile address width
//  LOAD_TIMEOUT  64  max WAIT_LOAD cycles before abort; 0 = watchdog disabled
// PORTS
//  clk_i            in   1      clock
//  rst_i            in   1      synchronous, active-high reset
//  mem_valid_i      in   1      MEM presents an instruction
//  mem_ready_o      out  1      WB can accept this cycle
//  flush_i          in   1      kill pending instruction
//  regfile_wr_en_i  in   1      instruction writes rd
//  rd_addr_i        in   RF_AW  destination register
//  wb_mux_sel_i     in   2      wb_options_e: ALU_RESULT, MEM_RESULT, NEXT_PC, CSR_RESULT
//  ex_rslt_i        in   XLEN   ALU result
//  next_pc_i        in   XLEN   pc+4 for JAL/JALR
//  csr_rdata_i      in   XLEN   CSR read value
//  load_type_i      in   3      funct3 of load
//  load_offset_i    in   3      addr low bits; [1:0] used at XLEN=32
//  l1d_rsp_valid_i  in   1      L1D read data valid
//  l1d_rd_data_i    in   XLEN   L1D read data, naturally aligned word/dword
//  regfile_wr_en_o  out  1      regfile write strobe
//  rd_addr_o        out  RF_AW  regfile write address
//  wb_data_o        out  XLEN   regfile write data
//  retire_o         out  1      one-cycle pulse per completed instruction
//  load_timeout_o   out  1      one-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except mem_ready_o=1; watchdog counter 0.
//  - Accept: mem_valid_i && mem_ready_o && !flush_i. Operands are captured into the stage register.
//  - FSM states are IDLE, WAIT_LOAD and WRITE.
//    - Accept with sel==MEM_RESULT goes to WAIT_LOAD. Any other accept goes to WRITE.
//    - WAIT_LOAD && l1d_rsp_valid_i: capture the extended load data, then go to WRITE.
//    - WRITE with a new accept: follow the accept rule above. WRITE without an accept: go to IDLE.
//  - mem_ready_o = (state != WAIT_LOAD). Non-loads sustain 1 instruction/cycle.
//  - Latency:
//    - Non-load accepted in cycle N writes in N+1.
//    - Load whose response arrives in cycle M writes in M+1.
//  - In WRITE: regfile_wr_en_o = captured wr_en && rd != 0; retire_o = 1 (also for rd == 0).
//  - Outside WRITE: regfile_wr_en_o = 0. rd_addr_o and wb_data_o hold their last values.
//  - Load extension, with byte lane chosen by offset:
//    - LB=000 and LH=001 sign-extend; LBU=100 and LHU=101 zero-extend.
//    - LW=010 sign-extends at XLEN=64 and passes through at XLEN=32.
//    - XLEN=64 only: LD=011 passes through; LWU=110 zero-extends.
//    - Halfword lane ignores offset[0]; word lane ignores offset[1:0]; any other funct3 passes raw data.
//  - l1d_rsp_valid_i outside WAIT_LOAD is ignored. No state change is permitted on it.
//  - Watchdog (LOAD_TIMEOUT > 0):
//    - The counter increments each WAIT_LOAD cycle without a response and clears on exit.
//    - When the counter reaches LOAD_TIMEOUT: pulse load_timeout_o, go to IDLE, no regfile write.
//    - A response in the same cycle wins over the timeout.
//  - flush_i:
//    - Forces IDLE next cycle and blocks accept that cycle.
//    - In WRITE, the current write still completes; flush kills only WAIT_LOAD and incoming work.
//    - A load response in the flush cycle is discarded.
//  - Reset mid-WAIT_LOAD: IDLE next cycle, no write, no retire.
// STRUCTURE
//  - kamus_pkg holds:
//    - wb_options_e, extended with CSR_RESULT = 2'd3;
//    - load_type_e with the funct3 encodings;
//    - wb_state_e {IDLE, WAIT_LOAD, WRITE}.
//  - Sub-module kamus_load_align (combinational): inputs data, load_type, offset; output extended data.
//  - The top level holds the FSM, stage register, watchdog and output mux.
// TESTING
//  1. ALU back-to-back: 3 accepts, rd=1,2,3, ex=0x11,0x22,0x33.
//     -> 3 consecutive writes in cycles N+1..N+3; mem_ready_o stays 1.
//  2. LB, offset=3, rsp data 0x80FF_0000 arriving 4 cycles later.
//     -> mem_ready_o=0 for 4 cycles; then write 0xFFFF_FF80.
//  3. LHU, offset=2, data 0x8001_1234 -> wb_data_o=0x0000_8001.
//     LH at offset=2 -> 0xFFFF_8001.
//  4. rd=0 NEXT_PC instruction -> retire_o=1 and regfile_wr_en_o=0.
//     CSR_RESULT sel with csr_rdata_i=0xDEAD_BEEF -> writes 0xDEAD_BEEF.
//  5. LOAD_TIMEOUT=8 with no response.
//     -> load_timeout_o pulses on the 8th WAIT_LOAD cycle; no write; mem_ready_o=1 next cycle.
//  6. flush_i in WAIT_LOAD with a simultaneous l1d_rsp_valid_i -> no write; IDLE.
//     rst_i mid-load -> all outputs return to reset values.

Source files
------------

// File: rtl/kamus_pkg.sv
// Shared types for the kamus write-back stage: write-back source select,
// load funct3 encodings and the stage FSM states.
package kamus_pkg;

  typedef enum logic [1:0] {
    ALU_RESULT = 2'd0,
    MEM_RESULT = 2'd1,
    NEXT_PC    = 2'd2,
    CSR_RESULT = 2'd3
  } wb_options_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_type_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOAD = 2'd1,
    WRITE     = 2'd2
  } wb_state_e;

  // Watchdog counter only has to hold 0 .. timeout-1.
  function automatic int wdog_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/kamus_load_align.sv
// Combinational load aligner: picks the byte/half/word lane addressed by the
// low address bits and sign- or zero-extends it to XLEN.
module kamus_load_align
  import kamus_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      load_type_i,
  input  logic [2:0]      offset_i,
  output logic [XLEN-1:0] data_o
);

  logic [2:0]      off;
  logic [XLEN-1:0] b_sh;
  logic [XLEN-1:0] h_sh;
  logic [XLEN-1:0] w_sh;
  logic [7:0]      b_lane;
  logic [15:0]     h_lane;
  logic [31:0]     w_lane;

  always_comb begin
    // offset[2] only selects a lane on a 64-bit datapath.
    off    = (XLEN == 64) ? offset_i : {1'b0, offset_i[1:0]};
    b_sh   = data_i >> {off, 3'b000};
    h_sh   = data_i >> {off[2:1], 4'b0000};
    w_sh   = data_i >> {off[2], 5'b00000};
    b_lane = b_sh[7:0];
    h_lane = h_sh[15:0];
    w_lane = w_sh[31:0];

    data_o = data_i;
    case (load_type_i)
      LB:      data_o = XLEN'($signed(b_lane));
      LH:      data_o = XLEN'($signed(h_lane));
      LBU:     data_o = XLEN'(b_lane);
      LHU:     data_o = XLEN'(h_lane);
      LW:      data_o = (XLEN == 64) ? XLEN'($signed(w_lane)) : data_i;
      LWU:     data_o = (XLEN == 64) ? XLEN'(w_lane) : data_i;
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/kamus_wb_unit.sv
// Write-back stage: registers the MEM/WB boundary, waits for L1D load data,
// and drives the regfile write port with a one-cycle WRITE state per instruction.
module kamus_wb_unit
  import kamus_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RF_AW        = 5,
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mem_valid_i,
  output logic             mem_ready_o,
  input  logic             flush_i,
  input  logic             regfile_wr_en_i,
  input  logic [RF_AW-1:0] rd_addr_i,
  input  logic [1:0]       wb_mux_sel_i,
  input  logic [XLEN-1:0]  ex_rslt_i,
  input  logic [XLEN-1:0]  next_pc_i,
  input  logic [XLEN-1:0]  csr_rdata_i,
  input  logic [2:0]       load_type_i,
  input  logic [2:0]       load_offset_i,
  input  logic             l1d_rsp_valid_i,
  input  logic [XLEN-1:0]  l1d_rd_data_i,
  output logic             regfile_wr_en_o,
  output logic [RF_AW-1:0] rd_addr_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             retire_o,
  output logic             load_timeout_o
);

  localparam int CNT_W = wdog_width(LOAD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (LOAD_TIMEOUT > 0) ? CNT_W'(LOAD_TIMEOUT - 1) : '0;

  wb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pending-load context, held while waiting for the L1D response.
  logic             ld_wr_en_q, ld_wr_en_d;
  logic [RF_AW-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]       ld_type_q, ld_type_d;
  logic [2:0]       ld_off_q, ld_off_d;

  // Write-port registers; they only change on entry to WRITE so the
  // address/data outputs hold their last values while idle or waiting.
  logic             out_wr_en_q, out_wr_en_d;
  logic [RF_AW-1:0] out_rd_q, out_rd_d;
  logic [XLEN-1:0]  out_data_q, out_data_d;

  wb_options_e      sel;
  logic             accept;
  logic             wdog_hit;
  logic [XLEN-1:0]  direct_data;
  logic [XLEN-1:0]  load_data;

  kamus_load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .data_i      (l1d_rd_data_i),
    .load_type_i (ld_type_q),
    .offset_i    (ld_off_q),
    .data_o      (load_data)
  );

  // Handshake: MEM holds mem_valid_i and its operands until a cycle where
  // mem_ready_o is high; the transfer happens on that clock edge unless
  // flush_i is also high, in which case the offered instruction is dropped.
  assign mem_ready_o = (state_q != WAIT_LOAD);
  assign accept      = mem_valid_i && mem_ready_o && !flush_i;
  assign sel         = wb_options_e'(wb_mux_sel_i);
  assign wdog_hit    = (LOAD_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    direct_data = ex_rslt_i;
    case (sel)
      NEXT_PC:    direct_data = next_pc_i;
      CSR_RESULT: direct_data = csr_rdata_i;
      default:    direct_data = ex_rslt_i;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ld_wr_en_d     = ld_wr_en_q;
    ld_rd_d        = ld_rd_q;
    ld_type_d      = ld_type_q;
    ld_off_d       = ld_off_q;
    out_wr_en_d    = out_wr_en_q;
    out_rd_d       = out_rd_q;
    out_data_d     = out_data_q;
    load_timeout_o = 1'b0;

    case (state_q)
      IDLE, WRITE: begin
        if (accept) begin
          if (sel == MEM_RESULT) begin
            state_d    = WAIT_LOAD;
            cnt_d      = '0;
            ld_wr_en_d = regfile_wr_en_i;
            ld_rd_d    = rd_addr_i;
            ld_type_d  = load_type_i;
            ld_off_d   = load_offset_i;
          end else begin
            state_d     = WRITE;
            out_wr_en_d = regfile_wr_en_i;
            out_rd_d    = rd_addr_i;
            out_data_d  = direct_data;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_LOAD: begin
        // Flush beats a same-cycle response; a response beats the watchdog.
        if (flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (l1d_rsp_valid_i) begin
          state_d     = WRITE;
          cnt_d       = '0;
          out_wr_en_d = ld_wr_en_q;
          out_rd_d    = ld_rd_q;
          out_data_d  = load_data;
        end else if (wdog_hit) begin
          state_d        = IDLE;
          cnt_d          = '0;
          load_timeout_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ld_wr_en_q  <= 1'b0;
      ld_rd_q     <= '0;
      ld_type_q   <= '0;
      ld_off_q    <= '0;
      out_wr_en_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_wr_en_q  <= ld_wr_en_d;
      ld_rd_q     <= ld_rd_d;
      ld_type_q   <= ld_type_d;
      ld_off_q    <= ld_off_d;
      out_wr_en_q <= out_wr_en_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
    end
  end

  // x0 is hardwired: the instruction still retires but never writes.
  assign retire_o        = (state_q == WRITE);
  assign regfile_wr_en_o = (state_q == WRITE) && out_wr_en_q && (out_rd_q != '0);
  assign rd_addr_o       = out_rd_q;
  assign wb_data_o       = out_data_q;

endmodule
